sede_host: RTL and testbench
============================

# sede_host

Host-side controller for the Sobel edge-detection engine. Reads a raster image from a synchronous pixel ROM and streams it to the engine's `pix_data` input, honouring the engine's `busy` back-pressure. Captures every `valid`/`edge_out` result into a result RAM, then signals completion; this is the testbench-facing / SoC-facing other end of the engine's pixel-in/edge-out interface.

## Interface
- `IMG_W`, default 32: image width in pixels.
- `IMG_H`, default 32: image height in pixels.
- `ADDR_W`, default 10: ROM/RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- `DRAIN_MAX`, default 2048: timeout cycles in DRAIN before aborting.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a frame; accepted in IDLE or DONE only.
- `rom_rd` out 1: ROM read strobe.
- `rom_addr` out ADDR_W: ROM read address.
- `rom_q` in 8: ROM data, valid exactly 1 cycle after `rom_rd`.
- `pix_data` out 8: pixel to engine.
- `busy` in 1: engine back-pressure; pixel not consumed while high.
- `valid` in 1: engine result strobe.
- `edge_out` in 8: engine result.
- `res_wr` out 1: result RAM write enable.
- `res_addr` out ADDR_W: result RAM address.
- `res_di` out 8: result RAM write data.
- `done` out 1: frame finished (level).
- `err` out 1: DRAIN timeout occurred (level, with `done`).
- `checksum` out 16: sum of captured results (see Configuration).

## Operation
- N = IMG_W*IMG_H. States: IDLE, FEED, DRAIN, DONE.
- IDLE: all outputs 0. `start` -> FEED; clears feed, capture and timeout counters, `err`, `checksum`.
- FEED: each cycle with `busy`=0 and feed count < N, assert `rom_rd`, `rom_addr` = feed count, increment. With `busy`=1, `rom_rd`=0 and `rom_addr` holds.
- Returning `rom_q` registers into `pix_data`. If `busy`=1 when data returns, it goes into a 1-entry skid register; it is presented on `pix_data` on the first cycle after `busy` falls, before any new ROM data. No pixel is dropped or duplicated.
- `pix_data` holds its last value while `busy`=1, and reads 0 once all N pixels have been presented.
- FEED -> DRAIN when the Nth pixel has been presented on `pix_data`.
- Capture runs in FEED and DRAIN. On each `valid`=1 with capture count < N:
  - `res_wr`=1, `res_addr` = capture count, `res_di` = `edge_out`; increment the count.
  - `valid` beyond N results is ignored.
- DRAIN: increments the timeout counter each cycle.
  - Capture count = N -> DONE, `err`=0.
  - Timeout counter = DRAIN_MAX-1 without N results -> DONE, `err`=1.
- DONE: `done`=1. `err` and `checksum` hold. `start` re-enters FEED (`done` drops the next cycle).
- `start` in FEED/DRAIN is ignored.
- Reset (asserted at any time, including mid-frame): state IDLE; all outputs and counters 0; skid register empty.

## Timing
- `start` at cycle 0 -> first `rom_rd` at cycle 1 -> first `pix_data` at cycle 3 (registered ROM + registered output), with `busy`=0.
- Unstalled feed: one pixel per cycle. Last `pix_data` at cycle N+2.
- `res_wr`/`res_addr`/`res_di` are registered: they appear 1 cycle after the sampled `valid`.
- `done` rises the cycle after the Nth `res_wr` (or after timeout).
- Counters are ADDR_W+1 bits wide, so N = 2^ADDR_W does not wrap. `checksum` wraps modulo 2^16.

## Configuration
- `SEDE_HOST_CHECKSUM_EN` defined: `checksum` accumulates each captured `res_di` (zero-extended to 16 bits) and is cleared on `start`.
- Not defined: the accumulator is not built and `checksum` is constant 0.

## Test plan
- Reset: `rst`=0 mid-FEED at pixel 500 -> all outputs 0 next cycle; a new `start` replays from `rom_addr`=0.
- Basic frame: ROM[i]=i[7:0], `busy`=0, engine model echoes input after 67 cycles -> 1024 writes, res_addr 0..1023, `done`=1, `err`=0.
- Back-pressure: `busy` high for 5 cycles starting when ROM data for pixel 100 is in flight -> engine receives pixels 0..1023 in order, pixel 100 exactly once.
- Timeout: engine returns only 1000 results, DRAIN_MAX=2048 -> `done`=1, `err`=1, 1000 writes.
- Excess/ignored: 1030 `valid` pulses and `start` pulsed during FEED -> exactly 1024 writes, no restart.
- Checksum (macro defined): all ROM 0x01, echoing engine -> `checksum`=0x0400; macro undefined -> `checksum`=0.

Source files
------------

// File: rtl/sede_host_if.sv
// Pixel-in / edge-out bus between sede_host and its ROM, result RAM and Sobel engine.
// master is the host's view; slave is the environment's view of the same wires.
interface sede_host_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic              rom_rd;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_q;
   logic [7:0]        pix_data;
   logic              busy;
   logic              valid;
   logic [7:0]        edge_out;
   logic              res_wr;
   logic [ADDR_W-1:0] res_addr;
   logic [7:0]        res_di;
   logic              done;
   logic              err;
   logic [15:0]       checksum;

   modport master (
      input  start, rom_q, busy, valid, edge_out,
      output rom_rd, rom_addr, pix_data, res_wr, res_addr, res_di, done, err, checksum
   );

   modport slave (
      output start, rom_q, busy, valid, edge_out,
      input  rom_rd, rom_addr, pix_data, res_wr, res_addr, res_di, done, err, checksum
   );
endinterface

// File: rtl/sede_host.sv
// Host controller for the Sobel engine: streams a ROM image in, captures results to RAM.
// Optional result accumulator on the checksum output is built when SEDE_HOST_CHECKSUM_EN is defined.
module sede_host #(
   parameter int IMG_W     = 32,
   parameter int IMG_H     = 32,
   parameter int ADDR_W    = 10,
   parameter int DRAIN_MAX = 2048
) (
   input  logic        clk,
   input  logic        rst,
   sede_host_if.master bus
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int TMO_W = $clog2(DRAIN_MAX + 1);
   localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(IMG_W * IMG_H);
   localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(IMG_W * IMG_H - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_MAX - 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  feed_cnt;
   logic [CNT_W-1:0]  pres_cnt;
   logic [CNT_W-1:0]  cap_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              rq_valid;
   logic              skid_valid;
   logic [7:0]        skid;
   logic [7:0]        pix_q;
   logic              res_wr_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic [7:0]        res_di_q;
   logic              done_q;
   logic              err_q;

   logic fetch;
   logic load_skid;
   logic load_rom;
   logic capture;

   // The ROM read is gated by the live busy so at most one word is ever in flight
   // when the engine stalls; that is what lets a single skid entry suffice.
   assign fetch     = (state == FEED) && !bus.busy && (feed_cnt < N_CNT);
   assign load_skid = (state == FEED) && !bus.busy && skid_valid;
   assign load_rom  = (state == FEED) && !bus.busy && !skid_valid && rq_valid;
   assign capture   = ((state == FEED) || (state == DRAIN)) && bus.valid && (cap_cnt < N_CNT);

   assign bus.rom_rd   = fetch;
   assign bus.rom_addr = (state == FEED) ? feed_cnt[ADDR_W-1:0] : '0;
   assign bus.pix_data = pix_q;
   assign bus.res_wr   = res_wr_q;
   assign bus.res_addr = res_addr_q;
   assign bus.res_di   = res_di_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;

`ifdef SEDE_HOST_CHECKSUM_EN
   logic [15:0] checksum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         checksum_q <= 16'h0000;
      end else if (((state == IDLE) || (state == DONE)) && bus.start) begin
         checksum_q <= 16'h0000;
      end else if (capture) begin
         checksum_q <= checksum_q + {8'h00, bus.edge_out};
      end
   end

   assign bus.checksum = checksum_q;
`else
   assign bus.checksum = 16'h0000;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         feed_cnt   <= '0;
         pres_cnt   <= '0;
         cap_cnt    <= '0;
         tmo_cnt    <= '0;
         rq_valid   <= 1'b0;
         skid_valid <= 1'b0;
         skid       <= 8'h00;
         pix_q      <= 8'h00;
         res_wr_q   <= 1'b0;
         res_addr_q <= '0;
         res_di_q   <= 8'h00;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         res_wr_q <= 1'b0;
         rq_valid <= fetch;

         if (capture) begin
            res_wr_q   <= 1'b1;
            res_addr_q <= cap_cnt[ADDR_W-1:0];
            res_di_q   <= bus.edge_out;
            cap_cnt    <= cap_cnt + 1'b1;
         end

         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state      <= FEED;
                  feed_cnt   <= '0;
                  pres_cnt   <= '0;
                  cap_cnt    <= '0;
                  tmo_cnt    <= '0;
                  skid_valid <= 1'b0;
                  pix_q      <= 8'h00;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
               end
            end

            FEED: begin
               if (fetch) begin
                  feed_cnt <= feed_cnt + 1'b1;
               end

               // Data returning into a stall parks in the skid; the skid always
               // drains ahead of fresh ROM data so pixel order is preserved.
               if (rq_valid && (bus.busy || skid_valid)) begin
                  skid       <= bus.rom_q;
                  skid_valid <= 1'b1;
               end else if (load_skid) begin
                  skid_valid <= 1'b0;
               end

               if (load_skid || load_rom) begin
                  pix_q    <= load_skid ? skid : bus.rom_q;
                  pres_cnt <= pres_cnt + 1'b1;
                  if (pres_cnt == N_LAST) begin
                     state   <= DRAIN;
                     tmo_cnt <= '0;
                  end
               end
            end

            DRAIN: begin
               if (!bus.busy) begin
                  pix_q <= 8'h00;
               end

               if (cap_cnt == N_CNT) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  pix_q  <= 8'h00;
               end else if (tmo_cnt == TMO_LAST) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
                  pix_q  <= 8'h00;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sede_host.sv
// Directed self-checking bench for sede_host (32x32 image, 67-cycle engine latency).
// Checksum expectations follow whether SEDE_HOST_CHECKSUM_EN is defined.
module tb_sede_host;

   logic clk = 1'b0;
   logic rst;

   sede_host_if #(.ADDR_W(10)) bus ();

   sede_host #(
      .IMG_W(32), .IMG_H(32), .ADDR_W(10), .DRAIN_MAX(2048)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] romMem [0:1023];

   // Synchronous ROM: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.rom_rd === 1'b1) bus.rom_q <= romMem[bus.rom_addr];
   end

   int passCount = 0;
   int checkCount = 0;

   logic [7:0]  pixLog     [0:1099];
   logic        romRdLog   [0:1099];
   logic [9:0]  romAddrLog [0:1099];
   logic [9:0]  wrAddrLog  [0:1099];
   logic [7:0]  wrDataLog  [0:1099];
   int          wrCycLog   [0:1099];
   int          wrCount;
   int          doneCyc;
   logic        errAtDone;
   logic [15:0] csAtDone;

`ifdef SEDE_HOST_CHECKSUM_EN
   localparam logic [15:0] CS_ONES = 16'h0400;
`else
   localparam logic [15:0] CS_ONES = 16'h0000;
`endif

   task automatic doReset();
      rst = 1'b0;
      bus.start = 1'b0;
      bus.busy = 1'b0;
      bus.valid = 1'b0;
      bus.edge_out = 8'h00;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
   endtask

   // Start a frame at cycle 0 and run up to maxCyc cycles (or 8 past done),
   // logging DUT outputs per cycle. The engine emits result k at cycle 70+k.
   task automatic applyStimulus(input int nRes, input int busyStart, input int busyLen,
                                input int restartCyc, input int maxCyc);
      wrCount = 0;
      doneCyc = -1;
      errAtDone = 1'b0;
      csAtDone = 16'h0000;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.busy = 1'b0;
      bus.valid = 1'b0;
      bus.edge_out = 8'h00;
      for (int c = 1; c <= maxCyc; c++) begin
         @(posedge clk); #1;
         bus.start = (c == restartCyc);
         bus.busy = (c >= busyStart) && (c < busyStart + busyLen);
         bus.valid = (c >= 70) && (c < 70 + nRes);
         bus.edge_out = bus.valid ? romMem[(c + 954) % 1024] : 8'h00;
         #1;
         if (c < 1100) begin
            pixLog[c] = bus.pix_data;
            romRdLog[c] = bus.rom_rd;
            romAddrLog[c] = bus.rom_addr;
         end
         if (bus.res_wr === 1'b1) begin
            if (wrCount < 1100) begin
               wrAddrLog[wrCount] = bus.res_addr;
               wrDataLog[wrCount] = bus.res_di;
               wrCycLog[wrCount] = c;
            end
            wrCount++;
         end
         if (doneCyc < 0 && bus.done === 1'b1) begin
            doneCyc = c;
            errAtDone = bus.err;
            csAtDone = bus.checksum;
         end
         if (doneCyc >= 0 && c >= doneCyc + 8) break;
      end
      bus.start = 1'b0;
      bus.busy = 1'b0;
      bus.valid = 1'b0;
      bus.edge_out = 8'h00;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 1024; i++) romMem[i] = 8'(i);
      doReset();
      #1;
      checkCount++;
      if ({bus.rom_rd, bus.rom_addr, bus.pix_data, bus.res_wr, bus.res_addr, bus.res_di,
           bus.done, bus.err, bus.checksum} !== 55'd0)
         $display("[TB] FAIL reset_outputs: got rd=%b addr=%0d pix=%0h wr=%b done=%b err=%b cs=%0h expected all 0",
                  bus.rom_rd, bus.rom_addr, bus.pix_data, bus.res_wr, bus.done, bus.err, bus.checksum);
      else passCount++;

      applyStimulus(1024, 0, 0, 0, 503);
      checkCount++;
      if (pixLog[503] !== 8'd244) $display("[TB] FAIL midframe_pix: got %0d expected 244", pixLog[503]);
      else passCount++;
      checkCount++;
      if (bus.res_addr !== 10'd432) $display("[TB] FAIL midframe_res_addr: got %0d expected 432", bus.res_addr);
      else passCount++;

      rst = 1'b0;
      @(posedge clk); #2;
      checkCount++;
      if ({bus.rom_rd, bus.rom_addr, bus.pix_data, bus.res_wr, bus.res_addr, bus.res_di,
           bus.done, bus.err, bus.checksum} !== 55'd0)
         $display("[TB] FAIL midframe_reset_outputs: got rd=%b addr=%0d pix=%0h wr=%b raddr=%0d done=%b expected all 0",
                  bus.rom_rd, bus.rom_addr, bus.pix_data, bus.res_wr, bus.res_addr, bus.done);
      else passCount++;
      rst = 1'b1;

      applyStimulus(1024, 0, 0, 0, 5);
      checkCount++;
      if ({romRdLog[1], romAddrLog[1]} !== {1'b1, 10'd0})
         $display("[TB] FAIL replay_first_read: got rd=%b addr=%0d expected rd=1 addr=0", romRdLog[1], romAddrLog[1]);
      else passCount++;
      checkCount++;
      if (romAddrLog[2] !== 10'd1) $display("[TB] FAIL replay_second_addr: got %0d expected 1", romAddrLog[2]);
      else passCount++;
      checkCount++;
      if ({pixLog[4], pixLog[5]} !== {8'd1, 8'd2})
         $display("[TB] FAIL replay_pixels: got %0d,%0d expected 1,2", pixLog[4], pixLog[5]);
      else passCount++;
   endtask

   task automatic test_basic();
      for (int i = 0; i < 1024; i++) romMem[i] = 8'(i);
      doReset();
      applyStimulus(1024, 0, 0, 0, 1300);
      checkCount++;
      if ({romRdLog[1], romAddrLog[1]} !== {1'b1, 10'd0})
         $display("[TB] FAIL basic_first_read: got rd=%b addr=%0d expected rd=1 addr=0", romRdLog[1], romAddrLog[1]);
      else passCount++;
      for (int c = 3; c <= 1026; c++) begin
         checkCount++;
         if (pixLog[c] !== 8'(c - 3)) $display("[TB] FAIL basic_pix cyc%0d: got %0d expected %0d", c, pixLog[c], 8'(c - 3));
         else passCount++;
      end
      checkCount++;
      if (pixLog[1027] !== 8'd0) $display("[TB] FAIL basic_pix_after_last: got %0d expected 0", pixLog[1027]);
      else passCount++;
      checkCount++;
      if (wrCount !== 1024) $display("[TB] FAIL basic_write_count: got %0d expected 1024", wrCount);
      else passCount++;
      checkCount++;
      if (wrCycLog[0] !== 71) $display("[TB] FAIL basic_first_write_cycle: got %0d expected 71", wrCycLog[0]);
      else passCount++;
      for (int k = 0; k < wrCount && k < 1024; k++) begin
         checkCount++;
         if ({wrAddrLog[k], wrDataLog[k]} !== {10'(k), 8'(k)})
            $display("[TB] FAIL basic_write %0d: got addr=%0d data=%0d expected addr=%0d data=%0d",
                     k, wrAddrLog[k], wrDataLog[k], k, 8'(k));
         else passCount++;
      end
      checkCount++;
      if (doneCyc !== 1095) $display("[TB] FAIL basic_done_cycle: got %0d expected 1095", doneCyc);
      else passCount++;
      checkCount++;
      if (errAtDone !== 1'b0) $display("[TB] FAIL basic_err: got %b expected 0", errAtDone);
      else passCount++;
   endtask

   task automatic test_back_pressure();
      int e;
      for (int i = 0; i < 1024; i++) romMem[i] = 8'(i);
      doReset();
      applyStimulus(1024, 102, 5, 0, 1300);
      checkCount++;
      if ({romRdLog[102], romAddrLog[102]} !== {1'b0, 10'd101})
         $display("[TB] FAIL bp_stalled_read: got rd=%b addr=%0d expected rd=0 addr=101", romRdLog[102], romAddrLog[102]);
      else passCount++;
      checkCount++;
      if ({romRdLog[107], romAddrLog[107]} !== {1'b1, 10'd101})
         $display("[TB] FAIL bp_resume_read: got rd=%b addr=%0d expected rd=1 addr=101", romRdLog[107], romAddrLog[107]);
      else passCount++;
      for (int c = 3; c <= 1032; c++) begin
         if (c <= 102) e = c - 3;
         else if (c <= 107) e = 99;
         else if (c <= 1031) e = c - 8;
         else e = 0;
         checkCount++;
         if (pixLog[c] !== 8'(e)) $display("[TB] FAIL bp_pix cyc%0d: got %0d expected %0d", c, pixLog[c], 8'(e));
         else passCount++;
      end
      checkCount++;
      if (doneCyc !== 1095) $display("[TB] FAIL bp_done_cycle: got %0d expected 1095", doneCyc);
      else passCount++;
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 1024; i++) romMem[i] = 8'(i);
      doReset();
      applyStimulus(1000, 0, 0, 0, 3300);
      checkCount++;
      if (wrCount !== 1000) $display("[TB] FAIL timeout_write_count: got %0d expected 1000", wrCount);
      else passCount++;
      checkCount++;
      if (doneCyc !== 3074) $display("[TB] FAIL timeout_done_cycle: got %0d expected 3074", doneCyc);
      else passCount++;
      checkCount++;
      if (errAtDone !== 1'b1) $display("[TB] FAIL timeout_err: got %b expected 1", errAtDone);
      else passCount++;

      bus.start = 1'b1;
      @(posedge clk); #2;
      bus.start = 1'b0;
      checkCount++;
      if ({bus.done, bus.err, bus.checksum} !== 18'd0)
         $display("[TB] FAIL restart_clears: got done=%b err=%b cs=%0h expected 0,0,0", bus.done, bus.err, bus.checksum);
      else passCount++;
      checkCount++;
      if ({bus.rom_rd, bus.rom_addr} !== {1'b1, 10'd0})
         $display("[TB] FAIL restart_first_read: got rd=%b addr=%0d expected rd=1 addr=0", bus.rom_rd, bus.rom_addr);
      else passCount++;
   endtask

   task automatic test_excess();
      for (int i = 0; i < 1024; i++) romMem[i] = 8'(i);
      doReset();
      applyStimulus(1030, 0, 0, 200, 1300);
      checkCount++;
      if (romAddrLog[201] !== 10'd200) $display("[TB] FAIL excess_no_restart_addr: got %0d expected 200", romAddrLog[201]);
      else passCount++;
      checkCount++;
      if (pixLog[203] !== 8'd200) $display("[TB] FAIL excess_no_restart_pix: got %0d expected 200", pixLog[203]);
      else passCount++;
      checkCount++;
      if (wrCount !== 1024) $display("[TB] FAIL excess_write_count: got %0d expected 1024", wrCount);
      else passCount++;
      checkCount++;
      if (doneCyc !== 1095) $display("[TB] FAIL excess_done_cycle: got %0d expected 1095", doneCyc);
      else passCount++;
   endtask

   task automatic test_checksum();
      for (int i = 0; i < 1024; i++) romMem[i] = 8'h01;
      doReset();
      applyStimulus(1024, 0, 0, 0, 1300);
      checkCount++;
      if (csAtDone !== CS_ONES) $display("[TB] FAIL checksum_value: got %0h expected %0h", csAtDone, CS_ONES);
      else passCount++;
      checkCount++;
      if (bus.checksum !== CS_ONES) $display("[TB] FAIL checksum_hold: got %0h expected %0h", bus.checksum, CS_ONES);
      else passCount++;
      checkCount++;
      if ({doneCyc, errAtDone} !== {32'd1095, 1'b0})
         $display("[TB] FAIL checksum_done: got cyc=%0d err=%b expected cyc=1095 err=0", doneCyc, errAtDone);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_pressure();
      test_timeout();
      test_excess();
      test_checksum();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got no completion expected finish before time 1000000");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
